l2_mem_responder: RTL and testbench
===================================

L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 SHALL have parameter offset_width, default 3, giving log2 of words per L2 line (N = 1<<offset_width).
REQ-002 SHALL have parameter ram_addr_width, default 16, giving the word-address width of the backing RAM.
REQ-003 SHALL have ports clk (in, 1, sole clock) and rstn (in, 1, reset, synchronous, active-high: 1 = reset).
REQ-004 SHALL have port addr_l2cache_mem_r (in, 32, read byte address).
REQ-005 SHALL have port addr_l2cache_mem_w (in, 32, write byte address).
REQ-006 SHALL have port dout_l2cache_mem (in, 32*N, write line; word k in bits [32k+31:32k]).
REQ-007 SHALL have port din_mem_l2cache (out, 32*N, read line returned to L2).
REQ-008 SHALL have ports l2cache_mem_req_r and l2cache_mem_req_w (in, 1 each, read/write request, held until the matching addrOK).
REQ-009 SHALL have port l2cache_mem_rdy (in, 1, L2 ready to accept dataOK).
REQ-010 SHALL have port l2cache_mem_SUC (in, 1): 1 = uncached single word, 0 = full line.
REQ-011 SHALL have ports l2cache_mem_wstrb (in, 4, byte enables for uncached write) and l2cache_mem_size (in, 2, informational only, ignored).
REQ-012 SHALL have ports mem_l2cache_addrOK_r, mem_l2cache_addrOK_w and mem_l2cache_dataOK (out, 1 each).
REQ-013 SHALL have RAM-side ports ram_en (out, 1), ram_we (out, 4), ram_addr (out, ram_addr_width), ram_wdata (out, 32) and ram_rdata (in, 32, valid one cycle after ram_en with ram_we = 0).

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, READ, RESP.
REQ-015 SHALL assert addrOK_w combinationally in IDLE when req_w = 1, and accept the write in that cycle.
REQ-016 SHALL assert addrOK_r combinationally in IDLE when req_r = 1 and req_w = 0; write has priority when both requests are present.
REQ-017 SHALL, on acceptance, latch address, SUC, wstrb and the write line; line accesses use the address with bits [offset_width+1:0] cleared.
REQ-018 SHALL form each RAM word address as latched_addr[ram_addr_width+1:2] plus the beat index.
REQ-019 SHALL, in WRITE, issue one RAM write per cycle, beats 0..N-1, with ram_we = 4'hF, then go to RESP.
REQ-020 SHALL, for an uncached write, issue a single beat using word 0 of the latched line and ram_we = latched wstrb.
REQ-021 SHALL, in READ, issue beat k in cycle k and capture ram_rdata into line word k one cycle later; after the last capture it SHALL go to RESP.
REQ-022 SHALL, for an uncached read, issue one beat; din word 0 = data read, all other words = 0.
REQ-023 SHALL, in RESP, hold dataOK = 1 and din stable until rdy = 1; on dataOK & rdy it SHALL return to IDLE.
REQ-024 SHALL deliver dataOK no earlier than: cached write T+N+1, cached read T+N+2, uncached write T+2, uncached read T+3 (T = addrOK cycle); these are the exact latencies when rdy = 1.
REQ-025 SHALL hold the beat counter at offset_width+1 bits, reset it on entering WRITE/READ, and SHALL not wrap within a transaction.
REQ-026 SHALL ignore requests arriving outside IDLE; addrOK SHALL be 0 outside IDLE.
REQ-027 SHALL drive ram_en = 0 and ram_we = 0 in IDLE and RESP.

Reset
REQ-028 SHALL, while rstn = 1, go to IDLE, clear the counter and latches, and drive every output to 0 (din_mem_l2cache = 0), including mid-transaction.
REQ-029 SHALL perform no RAM write in any cycle where rstn = 1.

Verification
REQ-030 Cached write addr_w = 0x100, line words 0x11..0x18, rdy = 1 -> addrOK_w at T; RAM words 0x40..0x47 written T+1..T+8; dataOK at T+9.
REQ-031 Cached read addr_r = 0x104 after REQ-030 -> line base 0x100; dataOK at T+10 with din words 0x11..0x18 in order.
REQ-032 req_r and req_w asserted together -> addrOK_w first; read accepted only after write dataOK, and returns the new data.
REQ-033 Uncached write 0x208, data 0xAABBCCDD, wstrb 4'b0011, over 0xFFFFFFFF -> uncached read returns 0xFFFFCCDD in word 0, rest 0, dataOK at T+3.
REQ-034 Read with rdy held 0 for 5 cycles after dataOK -> dataOK and din stable all 5 cycles; IDLE one cycle after rdy = 1.
REQ-035 rstn = 1 during WRITE beat 3 -> no further RAM writes, all outputs 0 next cycle, new request accepted after release.

Source files
------------

// File: rtl/l2_mem_responder_if.sv
// L2-cache <-> memory-responder handshake bus: request addresses, write line,
// returned read line and the addrOK/dataOK acknowledgements.
interface l2_mem_responder_if #(
  parameter int offset_width = 3
);
  localparam int LineBits = 32 * (1 << offset_width);

  logic [31:0]         addr_l2cache_mem_r;
  logic [31:0]         addr_l2cache_mem_w;
  logic [LineBits-1:0] dout_l2cache_mem;
  logic [LineBits-1:0] din_mem_l2cache;
  logic                l2cache_mem_req_r;
  logic                l2cache_mem_req_w;
  logic                l2cache_mem_rdy;
  logic                l2cache_mem_SUC;
  logic [3:0]          l2cache_mem_wstrb;
  logic [1:0]          l2cache_mem_size;
  logic                mem_l2cache_addrOK_r;
  logic                mem_l2cache_addrOK_w;
  logic                mem_l2cache_dataOK;

  // The L2 cache side drives requests and consumes acknowledgements.
  modport master (
    output addr_l2cache_mem_r, addr_l2cache_mem_w, dout_l2cache_mem,
           l2cache_mem_req_r, l2cache_mem_req_w, l2cache_mem_rdy,
           l2cache_mem_SUC, l2cache_mem_wstrb, l2cache_mem_size,
    input  din_mem_l2cache, mem_l2cache_addrOK_r, mem_l2cache_addrOK_w,
           mem_l2cache_dataOK
  );

  modport slave (
    input  addr_l2cache_mem_r, addr_l2cache_mem_w, dout_l2cache_mem,
           l2cache_mem_req_r, l2cache_mem_req_w, l2cache_mem_rdy,
           l2cache_mem_SUC, l2cache_mem_wstrb, l2cache_mem_size,
    output din_mem_l2cache, mem_l2cache_addrOK_r, mem_l2cache_addrOK_w,
           mem_l2cache_dataOK
  );
endinterface

// File: rtl/l2_mem_responder.sv
// Memory responder for an L2 cache: serialises line or single-word accesses
// onto a one-word-per-cycle synchronous RAM and returns a response handshake.
module l2_mem_responder #(
  parameter int offset_width   = 3,
  parameter int ram_addr_width = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  l2_mem_responder_if.slave         bus,
  output logic                      ram_en,
  output logic [3:0]                ram_we,
  output logic [ram_addr_width-1:0] ram_addr,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata
);

  localparam int Words = 1 << offset_width;
  localparam int CntW  = offset_width + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [ram_addr_width-1:0] addr_q, addr_d;
  logic                      suc_q, suc_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic [31:0]               wline_q [Words];
  logic [31:0]               wline_d [Words];
  logic [31:0]               rline_q [Words];
  logic [31:0]               rline_d [Words];

  logic                      addrOkR, addrOkW, ramEn;
  logic [3:0]                ramWe;
  logic [CntW-1:0]           beats;
  logic [offset_width-1:0]   wordIdx, capIdx;

  // Line accesses start at the line base; single-word accesses keep the word.
  function automatic logic [ram_addr_width-1:0] wordAddr(input logic [31:0] a, input logic suc);
    logic [ram_addr_width-1:0] w;
    w = a[ram_addr_width+1:2];
    if (!suc) w[offset_width-1:0] = '0;
    return w;
  endfunction

  assign beats   = suc_q ? CntW'(1) : CntW'(Words);
  assign wordIdx = cnt_q[offset_width-1:0];
  assign capIdx  = wordIdx - offset_width'(1);

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      suc_q   <= 1'b0;
      wstrb_q <= '0;
      wline_q <= '{default: '0};
      rline_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      suc_q   <= suc_d;
      wstrb_q <= wstrb_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    suc_d   = suc_q;
    wstrb_d = wstrb_q;
    wline_d = wline_q;
    rline_d = rline_q;
    addrOkR = 1'b0;
    addrOkW = 1'b0;
    ramEn   = 1'b0;
    ramWe   = 4'h0;

    unique case (state_q)
      IDLE: begin
        if (bus.l2cache_mem_req_w) begin
          addrOkW = 1'b1;
          state_d = WRITE;
          cnt_d   = '0;
          suc_d   = bus.l2cache_mem_SUC;
          wstrb_d = bus.l2cache_mem_wstrb;
          addr_d  = wordAddr(bus.addr_l2cache_mem_w, bus.l2cache_mem_SUC);
          for (int k = 0; k < Words; k++) begin
            wline_d[k] = bus.dout_l2cache_mem[32*k +: 32];
          end
        end else if (bus.l2cache_mem_req_r) begin
          addrOkR = 1'b1;
          state_d = READ;
          cnt_d   = '0;
          suc_d   = bus.l2cache_mem_SUC;
          addr_d  = wordAddr(bus.addr_l2cache_mem_r, bus.l2cache_mem_SUC);
          rline_d = '{default: '0};
        end
      end
      WRITE: begin
        ramEn = 1'b1;
        ramWe = suc_q ? wstrb_q : 4'hF;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == beats - CntW'(1)) state_d = RESP;
      end
      READ: begin
        // Issue runs one cycle ahead of capture, so READ lasts beats+1 cycles.
        if (cnt_q < beats) ramEn = 1'b1;
        if (cnt_q != '0) rline_d[capIdx] = ram_rdata;
        if (cnt_q == beats) state_d = RESP;
        else cnt_d = cnt_q + CntW'(1);
      end
      RESP: begin
        if (bus.l2cache_mem_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low combinationally so no RAM write escapes a reset cycle.
  always_comb begin
    bus.mem_l2cache_addrOK_r = 1'b0;
    bus.mem_l2cache_addrOK_w = 1'b0;
    bus.mem_l2cache_dataOK   = 1'b0;
    bus.din_mem_l2cache      = '0;
    ram_en                   = 1'b0;
    ram_we                   = 4'h0;
    ram_addr                 = '0;
    ram_wdata                = '0;
    if (!rstn) begin
      bus.mem_l2cache_addrOK_r = addrOkR;
      bus.mem_l2cache_addrOK_w = addrOkW;
      bus.mem_l2cache_dataOK   = (state_q == RESP);
      for (int k = 0; k < Words; k++) begin
        bus.din_mem_l2cache[32*k +: 32] = rline_q[k];
      end
      ram_en = ramEn;
      ram_we = ramWe;
      if (ramEn) begin
        ram_addr  = addr_q + ram_addr_width'(cnt_q);
        ram_wdata = wline_q[wordIdx];
      end
    end
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder: directed transactions push expected
// responses; a negedge monitor checks latency and returned line data.
module tb_l2_mem_responder;

  localparam int OffW = 3;
  localparam int N    = 8;
  localparam int LW   = 32 * N;
  localparam int AW   = 16;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  l2_mem_responder_if #(.offset_width(OffW)) bus ();

  logic          ramEn;
  logic [3:0]    ramWe;
  logic [AW-1:0] ramAddr;
  logic [31:0]   ramWdata;
  logic [31:0]   ramRdata;

  l2_mem_responder #(.offset_width(OffW), .ram_addr_width(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .ram_en   (ramEn),
    .ram_we   (ramWe),
    .ram_addr (ramAddr),
    .ram_wdata(ramWdata),
    .ram_rdata(ramRdata)
  );

  typedef struct {
    bit          isRead;
    logic [LW-1:0] line;
    int          tAccept;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] mem [65536];
  int          writeCyc [65536];
  bit          prevOk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-enabled synchronous RAM with one-cycle read latency; logs write cycles.
  always @(posedge clk) begin
    if (ramEn) begin
      if (ramWe == 4'h0) begin
        ramRdata <= mem[ramAddr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ramWe[b]) mem[ramAddr][8*b +: 8] <= ramWdata[8*b +: 8];
        end
        writeCyc[ramAddr] <= cyc;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] mkLine(input logic [31:0] base);
    logic [LW-1:0] r;
    for (int k = 0; k < N; k++) r[32*k +: 32] = base + 32'(k);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      checkOutput("ramWeInReset", LW'(ramWe), LW'(0));
    end else begin
      if (bus.mem_l2cache_dataOK && !prevOk) begin
        checkOutput("sbPending", LW'(sb.size() > 0), LW'(1));
        if (sb.size() > 0) checkOutput("latency", LW'(cyc - sb[0].tAccept), LW'(sb[0].lat));
      end
      if (bus.mem_l2cache_dataOK && sb.size() > 0 && sb[0].isRead)
        checkOutput("din", bus.din_mem_l2cache, sb[0].line);
      if (bus.mem_l2cache_dataOK && bus.l2cache_mem_rdy && sb.size() > 0)
        void'(sb.pop_front());
    end
    prevOk = bus.mem_l2cache_dataOK;
  end

  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input bit suc,
                               input logic [3:0] wstrb, input logic [LW-1:0] wline,
                               input logic [LW-1:0] expLine, input int lat,
                               input bit expectResp, output int tAcc);
    bit   found;
    exp_t e;
    @(posedge clk); #1;
    bus.l2cache_mem_SUC   = suc;
    bus.l2cache_mem_wstrb = wstrb;
    if (isWrite) begin
      bus.addr_l2cache_mem_w = addr;
      bus.dout_l2cache_mem   = wline;
      bus.l2cache_mem_req_w  = 1'b1;
    end else begin
      bus.addr_l2cache_mem_r = addr;
      bus.l2cache_mem_req_r  = 1'b1;
    end
    found = 1'b0;
    tAcc  = -1;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (isWrite ? bus.mem_l2cache_addrOK_w : bus.mem_l2cache_addrOK_r) begin
        found = 1'b1;
        tAcc  = cyc;
      end
    end
    checkOutput(isWrite ? "acceptW" : "acceptR", LW'(found), LW'(1));
    if (found && expectResp) begin
      e.isRead  = !isWrite;
      e.line    = expLine;
      e.tAccept = tAcc;
      e.lat     = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.l2cache_mem_req_w = 1'b0;
    bus.l2cache_mem_req_r = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drain", LW'(sb.size()), LW'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            t, tW, tR;
    bit            found;
    exp_t          e;
    logic [LW-1:0] ucLine;

    bus.addr_l2cache_mem_r = '0;
    bus.addr_l2cache_mem_w = '0;
    bus.dout_l2cache_mem   = '0;
    bus.l2cache_mem_req_r  = 1'b0;
    bus.l2cache_mem_req_w  = 1'b0;
    bus.l2cache_mem_rdy    = 1'b1;
    bus.l2cache_mem_SUC    = 1'b0;
    bus.l2cache_mem_wstrb  = 4'h0;
    bus.l2cache_mem_size   = 2'd2;
    for (int i = 0; i < 65536; i++) begin
      mem[i]      = 32'h0;
      writeCyc[i] = -1;
    end
    mem[16'h82] = 32'hFFFF_FFFF;

    $display("[TB] reset and idle outputs");
    rstn = 1'b1;
    bus.l2cache_mem_req_w = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstAddrOkW", LW'(bus.mem_l2cache_addrOK_w), LW'(0));
    checkOutput("rstDataOk", LW'(bus.mem_l2cache_dataOK), LW'(0));
    checkOutput("rstRamEn", LW'(ramEn), LW'(0));
    checkOutput("rstDin", bus.din_mem_l2cache, LW'(0));
    @(posedge clk); #1;
    bus.l2cache_mem_req_w = 1'b0;
    rstn = 1'b0;

    $display("[TB] cached line write");
    applyStimulus(1'b1, 32'h100, 1'b0, 4'hF, mkLine(32'h11), '0, 9, 1'b1, t);
    waitDrain();
    for (int k = 0; k < N; k++) begin
      checkOutput("memLine", LW'(mem[16'h40 + k]), LW'(32'h11 + 32'(k)));
      checkOutput("writeCycle", LW'(writeCyc[16'h40 + k]), LW'(t + 1 + k));
    end

    $display("[TB] cached line read from mid-line address");
    applyStimulus(1'b0, 32'h104, 1'b0, 4'h0, '0, mkLine(32'h11), 10, 1'b1, t);
    waitDrain();

    $display("[TB] simultaneous read and write requests");
    @(posedge clk); #1;
    bus.l2cache_mem_SUC    = 1'b0;
    bus.addr_l2cache_mem_w = 32'h140;
    bus.dout_l2cache_mem   = mkLine(32'h21);
    bus.addr_l2cache_mem_r = 32'h140;
    bus.l2cache_mem_req_w  = 1'b1;
    bus.l2cache_mem_req_r  = 1'b1;
    found = 1'b0;
    tW = -1;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_l2cache_addrOK_w) begin
        found = 1'b1;
        tW = cyc;
        checkOutput("writePriority", LW'(bus.mem_l2cache_addrOK_r), LW'(0));
      end
    end
    checkOutput("acceptBothW", LW'(found), LW'(1));
    e.isRead = 1'b0; e.line = '0; e.tAccept = tW; e.lat = 9;
    if (found) sb.push_back(e);
    @(posedge clk); #1;
    bus.l2cache_mem_req_w = 1'b0;
    found = 1'b0;
    tR = -1;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_l2cache_addrOK_r) begin
        found = 1'b1;
        tR = cyc;
      end
    end
    checkOutput("readAfterWrite", LW'(tR), LW'(tW + 10));
    e.isRead = 1'b1; e.line = mkLine(32'h21); e.tAccept = tR; e.lat = 10;
    if (found) sb.push_back(e);
    @(posedge clk); #1;
    bus.l2cache_mem_req_r = 1'b0;
    waitDrain();

    $display("[TB] uncached write with partial strobes, then uncached read");
    ucLine = mkLine(32'hDEAD_0000);
    ucLine[31:0] = 32'hAABB_CCDD;
    applyStimulus(1'b1, 32'h208, 1'b1, 4'b0011, ucLine, '0, 2, 1'b1, t);
    waitDrain();
    checkOutput("ucMerge", LW'(mem[16'h82]), LW'(32'hFFFF_CCDD));
    checkOutput("ucSingleBeat", LW'(mem[16'h83]), LW'(0));
    applyStimulus(1'b0, 32'h208, 1'b1, 4'h0, '0, LW'(32'hFFFF_CCDD), 3, 1'b1, t);
    waitDrain();

    $display("[TB] read with rdy held low");
    bus.l2cache_mem_rdy = 1'b0;
    applyStimulus(1'b0, 32'h140, 1'b0, 4'h0, '0, mkLine(32'h21), 10, 1'b1, t);
    for (int i = 0; i < 50 && !bus.mem_l2cache_dataOK; i++) @(negedge clk);
    checkOutput("dataOkSeen", LW'(bus.mem_l2cache_dataOK), LW'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("dataOkHeld", LW'(bus.mem_l2cache_dataOK), LW'(1));
    end
    @(posedge clk); #1;
    bus.l2cache_mem_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idleAfterRdy", LW'(bus.mem_l2cache_dataOK), LW'(0));
    waitDrain();

    $display("[TB] reset during write beat 3");
    applyStimulus(1'b1, 32'h300, 1'b0, 4'hF, mkLine(32'h31), '0, 9, 1'b0, t);
    for (int i = 0; i < 20 && cyc < t + 4; i++) begin
      @(posedge clk); #1;
    end
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("midRstRamEn", LW'(ramEn), LW'(0));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("postRstRamEn", LW'(ramEn), LW'(0));
    checkOutput("postRstDataOk", LW'(bus.mem_l2cache_dataOK), LW'(0));
    checkOutput("postRstDin", bus.din_mem_l2cache, LW'(0));
    @(posedge clk); #1;
    rstn = 1'b0;
    checkOutput("beat2Written", LW'(mem[16'hC2]), LW'(32'h33));
    checkOutput("beat3Blocked", LW'(mem[16'hC3]), LW'(0));
    applyStimulus(1'b0, 32'h300, 1'b0, 4'h0, '0,
                  {160'h0, 32'h33, 32'h32, 32'h31}, 10, 1'b1, t);
    waitDrain();

    checkOutput("sbEmpty", LW'(sb.size()), LW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
